mmio_uart_tx: RTL

Memory-mapped UART transmitter on the data-memory side of the `mips` core, consuming its `memwrite`, `bytemode`, `aluout` and `writedata`. Stores to the TX data register push a byte into an 8-entry FIFO; an 8N1 serializer drains it onto `txd`. Loads from the status register are muxed into the core's `readdata`. All other addresses pass through to data memory unchanged.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_uart_tx_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the TX FSM state encoding, the status bit layout and the register offsets.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [31:0] STAT_OFFSET = 32'd4;

    function automatic logic [31:0] status_word(input logic busy, input logic empty,
                                                input logic full, input logic ovf);
        logic [31:0] w;
        w            = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with binary pointers and an explicit occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the core's data-memory bus: TX data and status registers,
// an 8N1 serializer draining a byte FIFO, and pass-through for all other addresses.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          DIVISOR    = 5208,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        bytemode,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic [31:0] memreaddata,
    output logic        memwrite_mem,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        tx_busy
);

    localparam int          CW          = $clog2(DIVISOR);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIVISOR - 1);
    localparam logic [29:0] DATA_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0] STAT_WORD   = DATA_WORD + STAT_OFFSET[31:2];

    logic        hit_data;
    logic        hit_stat;
    logic        hit;
    logic        data_wr;
    logic        stat_wr;

    logic [7:0]  fifo_dout;
    logic        full;
    logic        empty;
    logic        pop;
    logic        overflow;

    tx_state_t   state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        txd_n;
    logic        bit_end;
    logic        fsm_busy;
    logic [31:0] status;

    // Byte-lane and width information is irrelevant to these registers.
    logic        unused_bits;
    assign unused_bits = ^{bytemode, aluout[1:0], writedata[31:8]};

    assign hit_data     = (aluout[31:2] == DATA_WORD);
    assign hit_stat     = (aluout[31:2] == STAT_WORD);
    assign hit          = hit_data | hit_stat;
    assign data_wr      = memwrite & hit_data;
    assign stat_wr      = memwrite & hit_stat;
    assign memwrite_mem = memwrite & ~hit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (pop),
        .din   (writedata[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (stat_wr && writedata[STAT_OVF]) begin
            overflow <= 1'b0;
        end else if (data_wr && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign fsm_busy = (state != IDLE);
    assign tx_busy  = fsm_busy | ~empty;
    assign status   = status_word(fsm_busy, empty, full, overflow);

    always_comb begin
        readdata = memreaddata;
        if (hit_stat)      readdata = status;
        else if (hit_data) readdata = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            txd     <= txd_n;
        end
    end

    assign bit_end = (baud == '0);

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    baud_n  = BAUD_RELOAD;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n    = BAUD_RELOAD;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n  = BAUD_RELOAD;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n   = STOP;
                    else                 bit_idx_n = bit_idx + 1'b1;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames have no gap.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        baud_n  = BAUD_RELOAD;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // txd is registered from the next-state view so the pin never glitches.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

endmodule
